// File: rtl/islem_istemci.sv
// Requester side of the operation-unit result handshake (4-phase: istek/hazir).
// Optional timeout logic is enabled by defining ZAMAN_ASIMI_EN.
//
// state | meaning
// BOS   | idle, waiting for basla
// BEKLE | istek high, waiting for hazir_in (or timeout)
// BIRAK | istek low, waiting for the unit to drop hazir_in
module islem_istemci #(
    parameter int VERI_GENISLIGI  = 32,
    parameter int SONUC_GENISLIGI = 64,
    parameter int ZAMAN_ASIMI     = 255,
    parameter int SAYAC_GENISLIGI = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       basla,
    input  logic [VERI_GENISLIGI-1:0]  giris_sayi,
    output logic [VERI_GENISLIGI-1:0]  sayi1,
    output logic                       istek,
    input  logic [SONUC_GENISLIGI-1:0] sonuc_in,
    input  logic                       tasma_in,
    input  logic                       hazir_in,
    input  logic                       gecerli_in,
    output logic [SONUC_GENISLIGI-1:0] sonuc,
    output logic                       tasma,
    output logic                       mesgul,
    output logic                       tamam,
    output logic                       hata,
    output logic                       zaman_asimi
);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        BEKLE = 2'd1,
        BIRAK = 2'd2
    } durum_t;

    durum_t                     durum, durum_next;
    logic [VERI_GENISLIGI-1:0]  sayi1_next;
    logic [SONUC_GENISLIGI-1:0] sonuc_next;
    logic                       tasma_next;
    logic                       tamam_next;
    logic                       hata_next;

`ifdef ZAMAN_ASIMI_EN
    localparam logic [SAYAC_GENISLIGI-1:0] SAYAC_SON = SAYAC_GENISLIGI'(ZAMAN_ASIMI);
    logic [SAYAC_GENISLIGI-1:0] sayac, sayac_next;
    logic                       asim_next;
`else
    logic unused_cfg;
    assign unused_cfg  = (ZAMAN_ASIMI == SAYAC_GENISLIGI);
    assign zaman_asimi = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum  <= BOS;
            sayi1  <= '0;
            istek  <= 1'b0;
            mesgul <= 1'b0;
            sonuc  <= '0;
            tasma  <= 1'b0;
            tamam  <= 1'b0;
            hata   <= 1'b0;
`ifdef ZAMAN_ASIMI_EN
            sayac       <= '0;
            zaman_asimi <= 1'b0;
`endif
        end else begin
            durum  <= durum_next;
            sayi1  <= sayi1_next;
            istek  <= (durum_next == BEKLE);
            mesgul <= (durum_next != BOS);
            sonuc  <= sonuc_next;
            tasma  <= tasma_next;
            tamam  <= tamam_next;
            hata   <= hata_next;
`ifdef ZAMAN_ASIMI_EN
            sayac       <= sayac_next;
            zaman_asimi <= asim_next;
`endif
        end
    end

    always_comb begin
        durum_next = durum;
        sayi1_next = sayi1;
        sonuc_next = sonuc;
        tasma_next = tasma;
        tamam_next = 1'b0;
        hata_next  = 1'b0;
`ifdef ZAMAN_ASIMI_EN
        sayac_next = sayac;
        asim_next  = 1'b0;
`endif
        case (durum)
            BOS: begin
                if (basla) begin
                    sayi1_next = giris_sayi;
                    durum_next = BEKLE;
`ifdef ZAMAN_ASIMI_EN
                    sayac_next = '0;
`endif
                end
            end
            BEKLE: begin
`ifdef ZAMAN_ASIMI_EN
                sayac_next = sayac + 1'b1;
`endif
                // hazir takes priority over a timeout landing on the same edge
                if (hazir_in) begin
                    if (gecerli_in) begin
                        sonuc_next = sonuc_in;
                        tasma_next = tasma_in;
                        tamam_next = 1'b1;
                    end else begin
                        hata_next = 1'b1;
                    end
                    durum_next = BIRAK;
`ifdef ZAMAN_ASIMI_EN
                    sayac_next = '0;
                end else if (sayac == SAYAC_SON) begin
                    asim_next  = 1'b1;
                    durum_next = BIRAK;
                    sayac_next = '0;
`endif
                end
            end
            BIRAK: begin
                if (!hazir_in) begin
                    durum_next = BOS;
`ifdef ZAMAN_ASIMI_EN
                end else if (sayac == SAYAC_SON) begin
                    // unit stuck with hazir high: give up silently
                    durum_next = BOS;
                end else begin
                    sayac_next = sayac + 1'b1;
`endif
                end
            end
            default: durum_next = BOS;
        endcase
    end

endmodule

// File: tb/tb_islem_istemci.sv
// Self-checking bench for islem_istemci: directed handshake cases plus randomized
// transactions checked against a transaction-level expectation of the requester.
module tb_islem_istemci;

    localparam int ZA = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        basla;
    logic [31:0] giris_sayi;
    logic [31:0] sayi1;
    logic        istek;
    logic [63:0] sonuc_in;
    logic        tasma_in;
    logic        hazir_in;
    logic        gecerli_in;
    logic [63:0] sonuc;
    logic        tasma;
    logic        mesgul;
    logic        tamam;
    logic        hata;
    logic        zaman_asimi;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_sonuc = '0;
    logic        exp_tasma = 1'b0;

    always #5 clk = ~clk;

    islem_istemci #(
        .VERI_GENISLIGI (32),
        .SONUC_GENISLIGI(64),
        .ZAMAN_ASIMI    (ZA),
        .SAYAC_GENISLIGI(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .basla      (basla),
        .giris_sayi (giris_sayi),
        .sayi1      (sayi1),
        .istek      (istek),
        .sonuc_in   (sonuc_in),
        .tasma_in   (tasma_in),
        .hazir_in   (hazir_in),
        .gecerli_in (gecerli_in),
        .sonuc      (sonuc),
        .tasma      (tasma),
        .mesgul     (mesgul),
        .tamam      (tamam),
        .hata       (hata),
        .zaman_asimi(zaman_asimi)
    );

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        total++;
        if (gozlenen !== beklenen) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic adim();
        @(posedge clk);
        #1;
    endtask

    // One request: unit answers d cycles after istek rises, hazir held h cycles.
    task automatic islem(input logic [31:0] sayi, input int d, input bit g, input int h,
                         input logic [63:0] r, input bit t, input bit basla_tut);
        basla      = 1'b1;
        giris_sayi = sayi;
        hazir_in   = 1'b0;
        gecerli_in = 1'b0;
        adim();
        kontrol("kabul_istek", istek, 1);
        kontrol("kabul_sayi1", sayi1, sayi);
        kontrol("kabul_mesgul", mesgul, 1);
        basla      = basla_tut;
        giris_sayi = $urandom;
        for (int i = 1; i <= d; i++) begin
            sonuc_in = {$urandom, $urandom};
            tasma_in = 1'($urandom);
            adim();
            kontrol("bekle_istek", istek, 1);
            kontrol("bekle_sayi1", sayi1, sayi);
            kontrol("bekle_darbe", {tamam, hata, zaman_asimi}, 0);
            kontrol("bekle_sonuc", sonuc, exp_sonuc);
        end
        hazir_in   = 1'b1;
        gecerli_in = g;
        sonuc_in   = r;
        tasma_in   = t;
        adim();
        if (g) begin
            exp_sonuc = r;
            exp_tasma = t;
        end
        kontrol("yanit_istek", istek, 0);
        kontrol("yanit_mesgul", mesgul, 1);
        kontrol("yanit_tamam", tamam, g);
        kontrol("yanit_hata", hata, !g);
        kontrol("yanit_asim", zaman_asimi, 0);
        kontrol("yanit_sonuc", sonuc, exp_sonuc);
        kontrol("yanit_tasma", tasma, exp_tasma);
        for (int i = 1; i < h; i++) begin
            sonuc_in   = {$urandom, $urandom};
            tasma_in   = 1'($urandom);
            gecerli_in = 1'($urandom);
            adim();
            kontrol("birak_istek", istek, 0);
            kontrol("birak_mesgul", mesgul, 1);
            kontrol("birak_darbe", {tamam, hata, zaman_asimi}, 0);
            kontrol("birak_sonuc", sonuc, exp_sonuc);
        end
        hazir_in   = 1'b0;
        gecerli_in = 1'b0;
        adim();
        kontrol("bos_mesgul", mesgul, 0);
        kontrol("bos_istek", istek, 0);
        kontrol("bos_darbe", {tamam, hata, zaman_asimi}, 0);
        kontrol("bos_sonuc", sonuc, exp_sonuc);
        kontrol("bos_tasma", tasma, exp_tasma);
        basla = 1'b0;
    endtask

`ifdef ZAMAN_ASIMI_EN
    task automatic asim_testi(input logic [31:0] sayi);
        basla      = 1'b1;
        giris_sayi = sayi;
        hazir_in   = 1'b0;
        adim();
        basla = 1'b0;
        for (int i = 1; i <= ZA; i++) begin
            adim();
            kontrol("asim_bekle_istek", istek, 1);
            kontrol("asim_bekle_darbe", zaman_asimi, 0);
        end
        adim();
        kontrol("asim_darbe", zaman_asimi, 1);
        kontrol("asim_istek", istek, 0);
        kontrol("asim_tamam", {tamam, hata}, 0);
        adim();
        kontrol("asim_tek", zaman_asimi, 0);
        kontrol("asim_bos", mesgul, 0);
        kontrol("asim_sonuc", sonuc, exp_sonuc);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        basla      = 1'b0;
        giris_sayi = '0;
        sonuc_in   = '0;
        tasma_in   = 1'b0;
        hazir_in   = 1'b0;
        gecerli_in = 1'b0;
        #12;
        kontrol("rst_cikis", {sayi1, istek, mesgul, tamam, hata, zaman_asimi, tasma}, 0);
        kontrol("rst_sonuc", sonuc, 0);
        rst_n = 1'b1;
        adim();
        kontrol("bos_basta", mesgul, 0);

        islem(32'h0000_002D, 5, 1'b1, 2, 64'h1, 1'b0, 1'b0);
        islem(32'h0000_0007, 3, 1'b0, 1, 64'hDEAD_BEEF_0000_1234, 1'b1, 1'b0);
        islem(32'h1234_5678, 1, 1'b1, 1, 64'hFFFF_0000_AAAA_5555, 1'b1, 1'b0);
        islem(32'h0BAD_F00D, 0, 1'b0, 2, 64'h0, 1'b0, 1'b0);
        islem(32'hCAFE_0001, 2, 1'b1, 1, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
        repeat (4) islem($urandom, 2, 1'b1, 3, {$urandom, $urandom}, 1'($urandom), 1'b1);
        islem(32'hFFFF_FFFF, 0, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

`ifdef ZAMAN_ASIMI_EN
        asim_testi(32'h0000_0042);
        islem(32'h0000_0043, ZA, 1'b1, 1, 64'h77, 1'b0, 1'b0);
`endif

        basla      = 1'b1;
        giris_sayi = 32'hA5A5_A5A5;
        adim();
        basla = 1'b0;
        adim();
        kontrol("rst_once_istek", istek, 1);
        #2 rst_n = 1'b0;
        #1;
        kontrol("rst_ani", {sayi1, istek, mesgul, tamam, hata, zaman_asimi, tasma}, 0);
        kontrol("rst_ani_sonuc", sonuc, 0);
        exp_sonuc = '0;
        exp_tasma = 1'b0;
        #3 rst_n = 1'b1;
        adim();
        kontrol("rst_sonra_bos", mesgul, 0);
        islem(32'h0000_0099, 2, 1'b1, 1, 64'h1234, 1'b0, 1'b0);

        repeat (40) begin
            islem($urandom, int'($urandom_range(0, 8)), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(1, 4)), {$urandom, $urandom}, 1'($urandom),
                  1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
